// File: rtl/stage_seq_if.sv
// Instruction-memory read port between stage_seq (master) and the memory (slave).
interface stage_seq_if;
  logic        req;
  logic [15:0] addr;
  logic        ack;
  logic [15:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/stage_seq.sv
// Multicycle fetch/execute sequencer for the rk16 core: two-halfword fetch, stepped execute stages.
// Optional stall watchdog enabled by defining STAGE_SEQ_WDT_EN.
module stage_seq #(
  parameter int unsigned MAX_STAGE = 15,
  parameter int unsigned WDT_LIMIT = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               halt_req,
  input  logic [15:0]        pc,
  stage_seq_if.master        mem,
  input  logic [3:0]         n_stage,
  input  logic               stall,
  output logic [31:0]        inst,
  output logic [3:0]         stage,
  output logic               inst_valid,
  output logic               pc_step,
  output logic               halted,
  output logic               wdt_err
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFetchLo = 3'd1;
  localparam logic [2:0] StFetchHi = 3'd2;
  localparam logic [2:0] StExec    = 3'd3;
  localparam logic [2:0] StHalt    = 3'd4;

  if (WDT_LIMIT == 0) begin : g_wdt_limit_chk
    $error("stage_seq: WDT_LIMIT must be nonzero");
  end

  logic [2:0]  state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [3:0]  stage_q, stage_d;
  logic [3:0]  last_stage;
  logic        retire;
  logic        wdt_trip;

  // n_stage of 0 behaves as a single-stage instruction
  always_comb begin
    last_stage = (n_stage == 4'd0) ? 4'd0 : n_stage - 4'd1;
    if ({28'd0, last_stage} > MAX_STAGE) begin
      last_stage = MAX_STAGE[3:0];
    end
  end

  assign retire = (state_q == StExec) && !stall && (stage_q == last_stage);

`ifdef STAGE_SEQ_WDT_EN
  localparam int unsigned WdtW = $clog2(WDT_LIMIT + 1);

  logic [WdtW-1:0] wdt_cnt_q, wdt_cnt_d;
  logic            wdt_err_q;

  // Counts consecutive stalled EXEC cycles; any other cycle clears it
  always_comb begin
    wdt_cnt_d = '0;
    wdt_trip  = 1'b0;
    if ((state_q == StExec) && stall) begin
      if (wdt_cnt_q == WdtW'(WDT_LIMIT - 1)) begin
        wdt_trip = 1'b1;
      end else begin
        wdt_cnt_d = wdt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt_q <= '0;
      wdt_err_q <= 1'b0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      if (wdt_trip) begin
        wdt_err_q <= 1'b1;
      end
    end
  end

  assign wdt_err = wdt_err_q;
`else
  assign wdt_trip = 1'b0;
  assign wdt_err  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    stage_d = stage_q;
    case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StFetchLo;
        end
      end
      StFetchLo: begin
        if (mem.ack) begin
          inst_d[15:0] = mem.rdata;
          state_d      = StFetchHi;
        end
      end
      StFetchHi: begin
        if (mem.ack) begin
          inst_d[31:16] = mem.rdata;
          stage_d       = 4'd0;
          state_d       = StExec;
        end
      end
      StExec: begin
        if (wdt_trip) begin
          stage_d = 4'd0;
          state_d = StHalt;
        end else if (retire) begin
          stage_d = 4'd0;
          if (halt_req) begin
            state_d = StHalt;
          end else if (run) begin
            state_d = StFetchLo;
          end else begin
            state_d = StIdle;
          end
        end else if (!stall) begin
          stage_d = stage_q + 4'd1;
        end
      end
      StHalt: begin
        if (!run) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      inst_q  <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      stage_q <= stage_d;
    end
  end

  // High half lives at pc+1; 16-bit wrap is intended
  assign mem.req  = (state_q == StFetchLo) || (state_q == StFetchHi);
  assign mem.addr = (state_q == StFetchLo) ? pc :
                    (state_q == StFetchHi) ? pc + 16'd1 : 16'd0;

  assign inst       = inst_q;
  assign stage      = stage_q;
  assign inst_valid = (state_q == StExec);
  assign pc_step    = retire;
  assign halted     = (state_q == StHalt);

endmodule
